system_timer_multi: RTL and testbench
=====================================

Name: system_timer_multi

Overview:
- Parametrised, multi-channel successor to the single-channel 16-bit interval timer.
- Provides NUM_CH independent down-counters of COUNTER_W bits, each with its own prescaler, period, snapshot and one-shot/continuous mode.
- Sits on the system Avalon-MM bus as a slave with a 32-bit data path.
- Drives one combined interrupt plus a per-channel interrupt vector.

Parameters:
NUM_CH, 4, number of timer channels (1..8)
COUNTER_W, 32, counter/period width in bits (8..32)
PRESCALE_W, 16, prescaler width in bits (1..32)
RESET_PERIOD, 49999, reset value of every channel's period and counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
address  in  clog2(NUM_CH)+3  word address: upper bits = channel, low 3 bits = register
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  registered read data
irq  out  1  OR of all channel interrupts
irq_vec  out  NUM_CH  per-channel interrupt (timeout & ITO)

Behaviour:
- Reset: one clock, asynchronous, active-high. On assertion, for every channel:
  - counter = period = RESET_PERIOD; prescale register = 0; prescale count = 0; snapshot = 0.
  - control = 0; running = 0; timeout = 0.
  - readdata = 0, irq = 0, irq_vec = 0.
  - Reset mid-count aborts immediately; no event is generated.
- Register map (per channel, low 3 address bits); registers narrower than 32 bits read with zero-extension:
  - 0 STATUS: bit0 TO, bit1 RUN. Any write clears TO.
  - 1 CONTROL: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP. START/STOP are write-only pulses and read as 0.
  - 2 PERIOD [COUNTER_W-1:0].
  - 3 SNAPSHOT: a write captures the live counter; a read returns the captured value.
  - 4 PRESCALE [PRESCALE_W-1:0].
  - 5 COUNT: live counter, read-only.
  - 6, 7: reserved, read 0.
  - Channel index ≥ NUM_CH: reads 0, writes ignored.
- Read latency: readdata is valid exactly 1 clk after the address is presented; it updates every cycle irrespective of chipselect.
- Tick:
  - While RUN=1, prescale count decrements each clk.
  - When prescale count is 0 it reloads from PRESCALE and asserts a 1-cycle tick, so ticks occur every PRESCALE+1 clks.
  - PRESCALE=0 gives a tick every clk.
  - The prescale count resets to 0 on START and on a PERIOD write.
- On tick:
  - counter≠0: decrement.
  - counter=0: reload from PERIOD and set TO. If CONT=0, clear RUN in the same cycle.
  - The counter never underflows or wraps.
  - PERIOD=0 gives a timeout on every tick.
- PERIOD write: next clk, counter ← new PERIOD and RUN ← 0 (forced reload); software must START again.
- Per-channel state machine {IDLE, RUN}:
  - IDLE→RUN on START.
  - RUN→IDLE on STOP, on a PERIOD write, or on a one-shot expiry.
  - START and STOP in the same write: START wins.
- Simultaneous STATUS-write clear and timeout event in the same clk: TO stays set (no lost events).
- Snapshot write coincident with a tick captures the pre-decrement value.
- irq_vec[i] = TO[i] & ITO[i], combinational from registers. irq = |irq_vec.
- Channels are fully independent; writes to one channel never affect another.

Decomposition:
- Package system_timer_pkg:
  - register offset constants REG_STATUS..REG_COUNT;
  - control bit indices CTRL_ITO, CTRL_CONT, CTRL_START, CTRL_STOP;
  - status bit indices ST_TO, ST_RUN.
- Sub-module system_timer_channel: one channel (prescaler, counter, state, registers, per-channel read mux).
  - Generated NUM_CH times.
  - The top level does address decode, the channel-select read mux, the readdata register and the irq OR.

Test Plan:
- Reset, then read ch0 PERIOD and COUNT → 49999 (0x0000C34F) both; STATUS=0; irq=0.
- Ch1: PERIOD=9, PRESCALE=0, CONTROL=ITO|CONT|START → TO rises 10 clks after the counter reload; irq_vec[1] and irq high; the next timeout follows 10 clks later. Write STATUS → irq low after 1 clk.
- Ch2: PERIOD=3, PRESCALE=4, CONTROL=START (one-shot) → counter steps 3,2,1,0 once per 5 clks; TO=1, RUN=0 afterwards; COUNT reads 3 (reloaded) and holds.
- Ch0 running with PERIOD=100: write PERIOD=5 mid-count → next clk COUNT=5 and RUN=0; no TO.
- Align a STATUS write with the cycle TO would set (PERIOD=0, PRESCALE=0, CONT) → TO remains 1.
- Write CONTROL=START|STOP → RUN=1. Write SNAPSHOT at COUNT=42 → SNAPSHOT reads 42 (pre-tick value). Access channel index ≥ NUM_CH → reads 0, no side effects.

Source files
------------

// File: rtl/system_timer_pkg.sv
// Shared register offsets, control/status bit positions and channel state type for the multi-channel timer.
package system_timer_pkg;

   localparam logic [2:0] REG_STATUS   = 3'd0;
   localparam logic [2:0] REG_CONTROL  = 3'd1;
   localparam logic [2:0] REG_PERIOD   = 3'd2;
   localparam logic [2:0] REG_SNAPSHOT = 3'd3;
   localparam logic [2:0] REG_PRESCALE = 3'd4;
   localparam logic [2:0] REG_COUNT    = 3'd5;

   localparam int CTRL_ITO   = 0;
   localparam int CTRL_CONT  = 1;
   localparam int CTRL_START = 2;
   localparam int CTRL_STOP  = 3;

   localparam int ST_TO  = 0;
   localparam int ST_RUN = 1;

   typedef enum logic {
      CH_IDLE = 1'b0,
      CH_RUN  = 1'b1
   } ch_state_t;

endpackage

// File: rtl/system_timer_channel.sv
// One timer channel: prescaler, down-counter, run state, registers and register read mux.
// Read mux is combinational; no backpressure, a write always takes effect on the next clk.
module system_timer_channel
   import system_timer_pkg::*;
#(
   parameter int COUNTER_W    = 32,
   parameter int PRESCALE_W   = 16,
   parameter int RESET_PERIOD = 49999
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr,
   input  logic [2:0]  reg_sel,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   logic [COUNTER_W-1:0]  period;
   logic [COUNTER_W-1:0]  counter;
   logic [COUNTER_W-1:0]  snapshot;
   logic [PRESCALE_W-1:0] presc;
   logic [PRESCALE_W-1:0] pcount;
   logic                  ito;
   logic                  cont;
   logic                  timeout;
   ch_state_t             state;
   ch_state_t             state_nxt;

   logic running, tick, expire;
   logic wr_status, wr_ctrl, wr_period, wr_snap, wr_presc;
   logic start, stop;

   assign wr_status = wr && (reg_sel == REG_STATUS);
   assign wr_ctrl   = wr && (reg_sel == REG_CONTROL);
   assign wr_period = wr && (reg_sel == REG_PERIOD);
   assign wr_snap   = wr && (reg_sel == REG_SNAPSHOT);
   assign wr_presc  = wr && (reg_sel == REG_PRESCALE);
   assign start     = wr_ctrl && wdata[CTRL_START];
   assign stop      = wr_ctrl && wdata[CTRL_STOP];

   assign running = (state == CH_RUN);
   assign tick    = running && (pcount == '0);
   // A period write forces a reload, so it also swallows any coincident expiry.
   assign expire  = tick && (counter == '0) && !wr_period;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= CH_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         CH_IDLE: if (start) state_nxt = CH_RUN;
         CH_RUN: begin
            if (wr_period)                      state_nxt = CH_IDLE;
            else if (start)                     state_nxt = CH_RUN;
            else if (stop || (expire && !cont)) state_nxt = CH_IDLE;
         end
         default: state_nxt = CH_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         period   <= COUNTER_W'(RESET_PERIOD);
         counter  <= COUNTER_W'(RESET_PERIOD);
         snapshot <= '0;
         presc    <= '0;
         pcount   <= '0;
         ito      <= 1'b0;
         cont     <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         if (wr_period) period <= wdata[COUNTER_W-1:0];
         if (wr_presc)  presc  <= wdata[PRESCALE_W-1:0];
         if (wr_snap)   snapshot <= counter;
         if (wr_ctrl) begin
            ito  <= wdata[CTRL_ITO];
            cont <= wdata[CTRL_CONT];
         end

         if (start || wr_period) pcount <= '0;
         else if (tick)          pcount <= presc;
         else if (running)       pcount <= pcount - 1'b1;

         if (wr_period)  counter <= wdata[COUNTER_W-1:0];
         else if (tick)  counter <= (counter == '0) ? period : counter - 1'b1;

         // A timeout event outranks a software clear in the same clk.
         if (expire)         timeout <= 1'b1;
         else if (wr_status) timeout <= 1'b0;
      end
   end

   always_comb begin
      rdata = '0;
      case (reg_sel)
         REG_STATUS: begin
            rdata[ST_TO]  = timeout;
            rdata[ST_RUN] = running;
         end
         REG_CONTROL: begin
            rdata[CTRL_ITO]  = ito;
            rdata[CTRL_CONT] = cont;
         end
         REG_PERIOD:   rdata = 32'(period);
         REG_SNAPSHOT: rdata = 32'(snapshot);
         REG_PRESCALE: rdata = 32'(presc);
         REG_COUNT:    rdata = 32'(counter);
         default:      rdata = '0;
      endcase
   end

   assign irq = timeout & ito;

endmodule

// File: rtl/system_timer_multi.sv
// NUM_CH-channel interval timer on an Avalon-MM slave; readdata is registered (1 clk latency).
// No wait states or backpressure; accesses to channel indices >= NUM_CH read 0 and are ignored.
module system_timer_multi
   import system_timer_pkg::*;
#(
   parameter int NUM_CH       = 4,
   parameter int COUNTER_W    = 32,
   parameter int PRESCALE_W   = 16,
   parameter int RESET_PERIOD = 49999
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [$clog2(NUM_CH)+2:0]  address,
   input  logic                       chipselect,
   input  logic                       write_n,
   input  logic [31:0]                writedata,
   output logic [31:0]                readdata,
   output logic                       irq,
   output logic [NUM_CH-1:0]          irq_vec
);

   localparam int ADDR_W = $clog2(NUM_CH) + 3;

   logic [ADDR_W-1:0] ch_sel;
   logic              wr_en;
   logic [31:0]       ch_rdata [NUM_CH];
   logic [31:0]       rd_mux;

   // Full-width channel field so non-power-of-two NUM_CH leaves the top indices unmapped.
   assign ch_sel = address >> 3;
   assign wr_en  = chipselect && !write_n;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      system_timer_channel #(
         .COUNTER_W    (COUNTER_W),
         .PRESCALE_W   (PRESCALE_W),
         .RESET_PERIOD (RESET_PERIOD)
      ) u_ch (
         .clk     (clk),
         .reset   (reset),
         .wr      (wr_en && (ch_sel == ADDR_W'(i))),
         .reg_sel (address[2:0]),
         .wdata   (writedata),
         .rdata   (ch_rdata[i]),
         .irq     (irq_vec[i])
      );
   end

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_sel == ADDR_W'(i)) rd_mux = ch_rdata[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) readdata <= '0;
      else       readdata <= rd_mux;
   end

   assign irq = |irq_vec;

endmodule

// File: tb/tb_system_timer_multi.sv
// Directed bench for system_timer_multi: register-access vector tables plus cycle-exact timing sequences.
module tb_system_timer_multi;
   import system_timer_pkg::*;

   localparam int NCH = 3;
   localparam int AW  = $clog2(NCH) + 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] address = '0;
   logic          chipselect = 1'b0;
   logic          write_n = 1'b1;
   logic [31:0]   writedata = '0;
   logic [31:0]   readdata;
   logic          irq;
   logic [NCH-1:0] irq_vec;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   system_timer_multi #(
      .NUM_CH       (NCH),
      .COUNTER_W    (32),
      .PRESCALE_W   (16),
      .RESET_PERIOD (49999)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq),
      .irq_vec    (irq_vec)
   );

   typedef struct {
      bit          is_wr;
      int          ch;
      int          rg;
      logic [31:0] data;
      logic [31:0] expv;
      string       name;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input bit w, input int ch, input int rg,
                               input logic [31:0] d, input logic [31:0] e, input string n);
      vec_t v;
      v.is_wr = w; v.ch = ch; v.rg = rg; v.data = d; v.expv = e; v.name = n;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
      end
   endtask

   // Called at a negedge; the write lands on the next posedge and the task returns at the following negedge.
   task automatic bus_wr(input int ch, input int rg, input logic [31:0] d);
      address = AW'(ch * 8 + rg); chipselect = 1'b1; write_n = 1'b0; writedata = d;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic bus_rd(input int ch, input int rg, output logic [31:0] d);
      address = AW'(ch * 8 + rg); chipselect = 1'b1; write_n = 1'b1;
      @(negedge clk);
      d = readdata;
      chipselect = 1'b0;
   endtask

   task automatic run_vecs(input int lo, input int hi);
      logic [31:0] rd;
      for (int i = lo; i < hi; i++) begin
         if (vecs[i].is_wr) bus_wr(vecs[i].ch, vecs[i].rg, vecs[i].data);
         else begin
            bus_rd(vecs[i].ch, vecs[i].rg, rd);
            check(vecs[i].name, rd, vecs[i].expv);
         end
      end
   endtask

   // Ch2 one-shot, PERIOD=3 PRESCALE=4: counter value j clks after the START edge.
   function automatic logic [31:0] exp_c2(input int j);
      if (j == 0)       return 32'd3;
      else if (j <= 5)  return 32'd2;
      else if (j <= 10) return 32'd1;
      else if (j <= 15) return 32'd0;
      else              return 32'd3;
   endfunction

   initial begin
      logic [31:0] rd;
      int g0, g1, g2;

      add(0, 0, REG_PERIOD,   0, 32'h0000C34F, "rst_ch0_period");
      add(0, 0, REG_COUNT,    0, 32'h0000C34F, "rst_ch0_count");
      add(0, 0, REG_STATUS,   0, 32'h0,        "rst_ch0_status");
      add(0, 0, REG_CONTROL,  0, 32'h0,        "rst_ch0_control");
      add(0, 0, REG_SNAPSHOT, 0, 32'h0,        "rst_ch0_snapshot");
      add(0, 0, REG_PRESCALE, 0, 32'h0,        "rst_ch0_prescale");
      add(0, 1, REG_COUNT,    0, 32'h0000C34F, "rst_ch1_count");
      g0 = vecs.size();
      add(1, 3, REG_PERIOD,  32'd7, 0, "");
      add(1, 3, REG_CONTROL, 32'd7, 0, "");
      add(1, 3, REG_STATUS,  32'd0, 0, "");
      add(0, 3, REG_STATUS,   0, 32'h0,  "oor_status");
      add(0, 3, REG_PERIOD,   0, 32'h0,  "oor_period");
      add(0, 3, REG_COUNT,    0, 32'h0,  "oor_count");
      add(0, 0, REG_PERIOD,   0, 32'd100, "indep_ch0_period");
      add(0, 1, REG_PERIOD,   0, 32'd9,   "indep_ch1_period");
      add(0, 2, REG_PERIOD,   0, 32'd3,   "indep_ch2_period");
      add(0, 2, REG_PRESCALE, 0, 32'd4,   "indep_ch2_prescale");
      add(0, 1, REG_STATUS,   0, 32'h1,   "ch1_status_stopped");
      add(0, 1, 6,            0, 32'h0,   "reserved6");
      add(0, 1, 7,            0, 32'h0,   "reserved7");
      g1 = vecs.size();
      add(0, 2, REG_COUNT,    0, 32'h0000C34F, "rst2_ch2_count");
      add(0, 2, REG_STATUS,   0, 32'h0,        "rst2_ch2_status");
      add(0, 2, REG_PRESCALE, 0, 32'h0,        "rst2_ch2_prescale");
      add(0, 2, REG_PERIOD,   0, 32'h0000C34F, "rst2_ch2_period");
      add(0, 0, REG_SNAPSHOT, 0, 32'h0,        "rst2_ch0_snapshot");
      g2 = vecs.size();

      repeat (2) @(negedge clk);
      check("rst_readdata", readdata, 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_irq_vec", 32'(irq_vec), 32'h0);
      reset = 1'b0;
      run_vecs(0, g0);

      // Ch1 continuous with interrupt, tick every clk.
      bus_wr(1, REG_PRESCALE, 32'd0);
      bus_wr(1, REG_PERIOD, 32'd9);
      bus_wr(1, REG_CONTROL, 32'h7);
      repeat (9) @(negedge clk);
      check("ch1_irq_before_to", 32'(irq_vec), 32'h0);
      @(negedge clk);
      check("ch1_irq_vec_to", 32'(irq_vec), 32'b010);
      check("ch1_irq_to", 32'(irq), 32'h1);
      bus_wr(1, REG_STATUS, 32'd0);
      check("ch1_irq_cleared", 32'(irq), 32'h0);
      repeat (8) @(negedge clk);
      check("ch1_irq_before_to2", 32'(irq), 32'h0);
      @(negedge clk);
      check("ch1_irq_to2", 32'(irq_vec), 32'b010);
      bus_wr(1, REG_CONTROL, 32'h8);

      // Ch2 one-shot with prescaler: watch COUNT every clk.
      bus_wr(2, REG_PRESCALE, 32'd4);
      bus_wr(2, REG_PERIOD, 32'd3);
      bus_wr(2, REG_CONTROL, 32'h4);
      address = AW'(2 * 8 + REG_COUNT);
      for (int k = 1; k <= 21; k++) begin
         @(negedge clk);
         check($sformatf("ch2_count_t%0d", k - 1), readdata, exp_c2(k - 1));
      end
      bus_rd(2, REG_STATUS, rd);
      check("ch2_status_oneshot", rd, 32'h1);
      check("ch2_no_irq", 32'(irq_vec), 32'h0);

      // Ch0 period rewrite while running.
      bus_wr(0, REG_PERIOD, 32'd100);
      bus_wr(0, REG_CONTROL, 32'h4);
      repeat (3) @(negedge clk);
      bus_rd(0, REG_STATUS, rd);
      check("ch0_running", rd, 32'h2);
      bus_wr(0, REG_PERIOD, 32'd5);
      bus_rd(0, REG_COUNT, rd);
      check("ch0_reload_count", rd, 32'd5);
      bus_rd(0, REG_STATUS, rd);
      check("ch0_reload_status", rd, 32'h0);

      // Status clear coincident with an expiry.
      bus_wr(0, REG_PERIOD, 32'd0);
      bus_wr(0, REG_CONTROL, 32'h6);
      bus_wr(0, REG_STATUS, 32'd0);
      bus_rd(0, REG_STATUS, rd);
      check("clear_vs_timeout", rd, 32'h3);
      bus_wr(0, REG_CONTROL, 32'h8);
      bus_rd(0, REG_STATUS, rd);
      check("ch0_stopped", rd, 32'h1);
      bus_wr(0, REG_CONTROL, 32'hC);
      bus_rd(0, REG_STATUS, rd);
      check("start_beats_stop", rd, 32'h3);
      bus_rd(0, REG_CONTROL, rd);
      check("control_pulses_read0", rd, 32'h0);
      bus_wr(0, REG_CONTROL, 32'h8);

      // Snapshot write lands on the edge where the counter is 42 and a tick occurs.
      bus_wr(0, REG_PERIOD, 32'd100);
      bus_wr(0, REG_CONTROL, 32'h4);
      repeat (58) @(negedge clk);
      bus_wr(0, REG_SNAPSHOT, 32'd0);
      bus_rd(0, REG_COUNT, rd);
      check("snap_live_count", rd, 32'd41);
      bus_rd(0, REG_SNAPSHOT, rd);
      check("snap_value", rd, 32'd42);
      bus_wr(0, REG_CONTROL, 32'h8);

      run_vecs(g0, g1);
      check("oor_irq", 32'(irq), 32'h0);

      // Reset in the middle of a count.
      bus_wr(2, REG_CONTROL, 32'h7);
      repeat (3) @(negedge clk);
      check("ch2_irq_pre_reset", 32'(irq), 32'h1);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_irq", 32'(irq), 32'h0);
      check("midrst_readdata", readdata, 32'h0);
      reset = 1'b0;
      run_vecs(g1, g2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
